fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing one FIFO write port (valid/ready stream) among NUM_REQ requester streams.
- Grants one requester at a time for a burst of up to BURST_LEN beats, then rotates priority.
- Registered single-entry output stage drives the FIFO write side (wrDataIn/wrValidIn/wrReadyOut of the downstream FIFO).
- Sits between DMA/accelerator producers and the shared input FIFO.

Parameters:
- DATA_WIDTH, 32, width of each data beat.
- NUM_REQ, 4, number of requesters (2..16).
- BURST_LEN, 8, max beats per grant (1..256).
- Derived: ID_WIDTH = $clog2(NUM_REQ) (min 1); BCNT_WIDTH = $clog2(BURST_LEN+1).

Ports:
- clkIn  input  1  clock; all logic on rising edge.
- rstNIn  input  1  synchronous, active-low reset.
- reqDataIn  input  NUM_REQ*DATA_WIDTH  packed requester data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqValidIn  input  NUM_REQ  per-requester valid.
- reqReadyOut  output  NUM_REQ  per-requester ready; at most one bit set.
- outDataOut  output  DATA_WIDTH  registered beat to FIFO.
- outValidOut  output  1  output beat valid.
- outReadyIn  input  1  FIFO ready (FIFO wrReadyOut).
- grantIdOut  output  ID_WIDTH  index of current or last grant holder.
- busyOut  output  1  high while in GRANT state.

Behaviour:
- Reset (rstNIn==0 at a clock edge): state=IDLE, rrPtr=0, grantIdOut=0, beatCnt=0, outValidOut=0, reqReadyOut=0, busyOut=0. outDataOut is don't-care. Any beat held in the output register is discarded.
- Slot available: slotFree = !outValidOut | outReadyIn.
- reqReadyOut[i] = (state==GRANT) & (grantId==i) & slotFree. This is combinational; there is no dependency on reqValidIn.
- Accepted beat: reqValidIn[g] & reqReadyOut[g]. On that edge, the output register loads reqData[g] and outValidOut=1.
- Output register update:
  - If outValidOut & outReadyIn and no new beat is accepted, outValidOut clears.
  - Simultaneous drain and load keeps outValidOut=1 with the new data.
  - Full throughput: one beat per cycle.
- Latency: accepted input beat appears on outDataOut/outValidOut the next cycle.
- Ordering: beats from one requester leave in acceptance order. Beats are never dropped or duplicated.
- State machine:
  - IDLE:
    - If any reqValidIn is set, pick the first set index scanning rrPtr, rrPtr+1, … modulo NUM_REQ.
    - Latch grantId, clear beatCnt, go to GRANT next cycle. This is a one-cycle arbitration bubble; no ready is asserted in IDLE.
    - If no valid is set, stay in IDLE.
  - GRANT:
    - Each accepted beat increments beatCnt.
    - Release when the accepted beat makes beatCnt==BURST_LEN.
    - Also release when slotFree & !reqValidIn[grantId], i.e. the holder idles while it could have transferred.
    - On release: state=IDLE next cycle and rrPtr = (grantId+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
  - No release while backpressured: if slotFree==0, the grant holds regardless of the holder's valid.
- busyOut=1 exactly in GRANT.
- grantIdOut holds its value through IDLE until the next grant.
- Fairness: a continuously valid requester waits at most (NUM_REQ-1)*(BURST_LEN+1) accepted-beat-or-bubble cycles, excluding backpressure.
- Requesters must hold data stable while valid & !ready. Valid may drop without a transfer; this causes release as above.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds ports statsSelIn (input, ID_WIDTH) and statsCountOut (output, 32).
  - Per-requester 32-bit accepted-beat counters, reset to 0, wrap at 2^32-1 → 0.
  - statsCountOut is the registered value of counter[statsSelIn], one-cycle read latency.
  - A beat accepted in cycle t is visible if selected in cycle t+2.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: reqValidIn=4'b0010, 3 beats 0xA0..0xA2, outReadyIn=1.
  - grantIdOut=1, bubble then beats on consecutive cycles, outDataOut A0,A1,A2 one cycle after acceptance.
  - Valid drop → release; rrPtr=2.
- All four valid continuously, BURST_LEN=8, outReadyIn=1.
  - Grants rotate 0,1,2,3,0.
  - Exactly 8 beats per grant, one IDLE bubble between grants, no beat lost (verify 64 beats by scoreboard).
- Backpressure: requester 0 streaming, outReadyIn held 0 for 5 cycles mid-burst while requester 0 drops valid.
  - reqReadyOut=0 and outValidOut stays 1 with data stable.
  - Grant is held until outReadyIn=1, then release.
- Wrap-around: rrPtr=3, requesters 0 and 3 valid → grant 3 first, then 0.
- Reset mid-burst: assert rstNIn=0 with outValidOut=1.
  - Next cycle outValidOut=0, reqReadyOut=0, grantIdOut=0, busyOut=0.
  - After release, arbitration restarts from index 0.
- ARB_STATS_EN: 8 beats from requester 2, statsSelIn=2 → statsCountOut=8 two cycles after the last acceptance. Counters for the other requesters read 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready
// producer streams. Define ARB_STATS_EN to add per-requester accepted-beat counters.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 8,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BCNT_WIDTH = $clog2(BURST_LEN + 1)
) (
  input  logic                          clkIn,
  input  logic                          rstNIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [DATA_WIDTH-1:0]         outDataOut,
  output logic                          outValidOut,
  input  logic                          outReadyIn,
  output logic [ID_WIDTH-1:0]           grantIdOut,
`ifdef ARB_STATS_EN
  input  logic [ID_WIDTH-1:0]           statsSelIn,
  output logic [31:0]                   statsCountOut,
`endif
  output logic                          busyOut
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a producer holds data stable while valid & !ready.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int SCAN_WIDTH = ID_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [BCNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic                    slot_free;
  logic                    holder_valid;
  logic [DATA_WIDTH-1:0]   holder_data;
  logic                    accept;
  logic                    burst_done;
  logic                    release_grant;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic                    pick_found;
  logic [ID_WIDTH-1:0]     pick_id;
  logic [SCAN_WIDTH-1:0]   scan_idx;

  assign slot_free = !out_valid_q || outReadyIn;

  always_comb begin : holder_mux
    holder_valid = 1'b0;
    holder_data  = '0;
    reqReadyOut  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        holder_valid   = reqValidIn[i];
        holder_data    = reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
        reqReadyOut[i] = (state_q == ST_GRANT) && slot_free;
      end
    end
  end

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SCAN_WIDTH'(k);
      if (scan_idx >= SCAN_WIDTH'(NUM_REQ)) begin
        scan_idx = scan_idx - SCAN_WIDTH'(NUM_REQ);
      end
      if (!pick_found && reqValidIn[scan_idx[ID_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  assign accept        = (state_q == ST_GRANT) && slot_free && holder_valid;
  assign burst_done    = (beat_cnt_q == BCNT_WIDTH'(BURST_LEN - 1));
  // A backpressured holder keeps its grant even if its valid drops.
  assign release_grant = (state_q == ST_GRANT) &&
                         ((accept && burst_done) || (slot_free && !holder_valid));
  assign next_ptr      = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : grant_id_q + ID_WIDTH'(1);

  always_comb begin : fsm_next
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BCNT_WIDTH'(1);
        end
        if (release_grant) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : out_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = holder_data;
    end else if (outReadyIn) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign outDataOut  = out_data_q;
  assign outValidOut = out_valid_q;
  assign grantIdOut  = grant_id_q;
  assign busyOut     = (state_q == ST_GRANT);

`ifdef ARB_STATS_EN
  logic [31:0] stat_cnt_q [NUM_REQ];
  logic [31:0] stat_cnt_d [NUM_REQ];
  logic [31:0] stats_count_q, stats_count_d;

  // Counters wrap naturally at 2^32; the read port adds one register stage.
  always_comb begin : stats_next
    stats_count_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (accept && (grant_id_q == ID_WIDTH'(i))) begin
        stat_cnt_d[i] = stat_cnt_q[i] + 32'd1;
      end
      if (statsSelIn == ID_WIDTH'(i)) begin
        stats_count_d = stat_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt_q[i] <= '0;
      end
      stats_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt_q[i] <= stat_cnt_d[i];
      end
      stats_count_q <= stats_count_d;
    end
  end

  assign statsCountOut = stats_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: randomized and directed producer traffic checked by a
// spec-level reference model and an in-order expected-data scoreboard.
module tb_fifo_wr_arbiter;

  localparam int DW    = 32;
  localparam int N     = 4;
  localparam int BL    = 8;
  localparam int IW    = 2;
  localparam int DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [IW-1:0]   stats_sel;
  logic [31:0]     stats_count;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .BURST_LEN  (BL)
  ) dut (
    .clkIn         (clk),
    .rstNIn        (rst_n),
    .reqDataIn     (req_data),
    .reqValidIn    (req_valid),
    .reqReadyOut   (req_ready),
    .outDataOut    (out_data),
    .outValidOut   (out_valid),
    .outReadyIn    (out_ready),
    .grantIdOut    (grant_id),
`ifdef ARB_STATS_EN
    .statsSelIn    (stats_sel),
    .statsCountOut (stats_count),
`endif
    .busyOut       (busy)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  int pops = 0;

  logic [DW-1:0] exp_q[$];
  int dut_log[$];
  int exp_log[$];
  bit prev_busy = 1'b0;

  logic [DW-1:0] src_mem [N][DEPTH];
  int src_head [N];
  int src_tail [N];
  logic [N-1:0] en_mask;

  // Reference model: who holds the grant (-1 none), rotation pointer, beats in burst.
  int m_holder = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_last = 0;
  int m_acc = -1;
  bit m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : ref_model
    bit slot;
    bit found;
    slot  = !m_ov || out_ready;
    found = 1'b0;
    m_acc = -1;
    if (!rst_n) begin
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      m_last   = 0;
      m_ov     = 1'b0;
      exp_q.delete();
    end else begin
      if (m_holder >= 0 && slot && req_valid[m_holder]) m_acc = m_holder;
      if (m_acc >= 0) begin
        m_od = req_data[m_acc*DW +: DW];
        m_ov = 1'b1;
        exp_q.push_back(m_od);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_holder < 0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found    = 1'b1;
            m_holder = (m_ptr + k) % N;
            m_last   = m_holder;
            m_cnt    = 0;
          end
        end
      end else if (m_acc >= 0) begin
        m_cnt++;
        if (m_cnt == BL) begin
          m_ptr    = (m_holder + 1) % N;
          m_holder = -1;
        end
      end else if (slot && !req_valid[m_holder]) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_rdy;
    if (checking) begin
      exp_rdy = '0;
      if (m_holder >= 0 && (!m_ov || out_ready)) exp_rdy[m_holder] = 1'b1;
      check("ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), (m_holder >= 0) ? 32'd1 : 32'd0);
      check("grant_id", 32'(grant_id), 32'(m_last));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (busy && !prev_busy) dut_log.push_back(int'(grant_id));
      prev_busy = busy;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty actual=%0h required=no_beat at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // vmode: 0 valid whenever data queued, 1 random valid, 2 valid off.
  // rmode: 0 ready high, 1 random ready, 2 ready low.
  task automatic step(input int vmode, input int rmode, input bit rst_val);
    bit has;
    bit v;
    @(posedge clk);
    #1;
    if (m_acc >= 0) src_head[m_acc]++;
    rst_n = rst_val;
    for (int i = 0; i < N; i++) begin
      has = src_head[i] < src_tail[i];
      req_data[i*DW +: DW] = has ? src_mem[i][src_head[i]] : '0;
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b0;
      endcase
      req_valid[i] = has && en_mask[i] && v;
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic add_beats(input int r, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      src_mem[r][src_tail[r]] = base + DW'(k);
      src_tail[r]++;
    end
  endtask

  function automatic bit sources_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (src_head[i] < src_tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    en_mask = '1;
    while (n < 500 && !(sources_empty() && exp_q.size() == 0 && m_holder < 0 && !m_ov)) begin
      step(0, 0, 1'b1);
      n++;
    end
    tests++;
    if (n >= 500) begin
      fails++;
      $display("FAIL drain_timeout_%s actual=%0d_cycles required=<500", name, n);
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, dut_log.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < dut_log.size(); k++) begin
      check(name, dut_log[k], exp_log[k]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int pops0;
    logic [DW-1:0] held;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    en_mask   = '0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
`ifdef ARB_STATS_EN
    stats_sel = '0;
`endif
    step(2, 2, 1'b0);
    step(2, 2, 1'b0);
    checking = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single requester 1, beats A0..A2, then valid drops
    en_mask = 4'b0010;
    add_beats(1, 3, 32'h0000_00A0);
    dut_log.delete();
    for (int c = 0; c < 10; c++) step(0, 0, 1'b1);
    drain("single");
    exp_log.delete();
    exp_log.push_back(1);
    check_log("single_grants");

    // Pointer now 2: requesters 0 and 3 -> 3 first, then wrap to 0
    en_mask = 4'b1001;
    add_beats(0, 2, 32'h0003_0000);
    add_beats(3, 2, 32'h0303_0000);
    dut_log.delete();
    drain("wrap");
    exp_log.delete();
    exp_log.push_back(3);
    exp_log.push_back(0);
    check_log("wrap_grants");

    // All four streaming: bursts of BL, rotation from 0 after reset
    step(2, 2, 1'b0);
    en_mask = '1;
    for (int i = 0; i < N; i++) add_beats(i, 16, {8'(i), 8'h04, 16'h0});
    dut_log.delete();
    pops0 = pops;
    drain("all_four");
    check("all_four_beats", pops - pops0, 64);
    exp_log.delete();
    for (int k = 0; k < 8; k++) exp_log.push_back(k % N);
    check_log("all_four_grants");

    // Backpressure while holder drops valid
    en_mask = 4'b0001;
    add_beats(0, 10, 32'h0005_0000);
    dut_log.delete();
    for (int c = 0; c < 4; c++) step(0, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(2, 2, 1'b1);
      @(negedge clk);
      held = src_mem[0][src_head[0] - 1];
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_data_stable", out_data, held);
    end
    step(2, 0, 1'b1);
    step(2, 0, 1'b1);
    @(negedge clk);
    check("bp_release_busy", 32'(busy), 32'd0);
    exp_log.delete();
    exp_log.push_back(0);
    check_log("bp_grants");
    drain("bp");

    // Reset mid-burst with a beat in the output register
    en_mask = 4'b0010;
    add_beats(1, 6, 32'h0106_0000);
    add_beats(3, 3, 32'h0306_0000);
    for (int c = 0; c < 3; c++) step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    step(0, 0, 1'b1);
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_grant", 32'(grant_id), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    en_mask = 4'b1010;
    dut_log.delete();
    drain("rst_mid");
    exp_log.delete();
    exp_log.push_back(1);
    exp_log.push_back(3);
    check_log("rst_mid_grants");

    // Randomized valid and backpressure on all requesters
    en_mask = '1;
    for (int i = 0; i < N; i++) add_beats(i, 40, {8'(i), 8'h07, 16'h0});
    for (int c = 0; c < 500; c++) step(1, 1, 1'b1);
    drain("random");

`ifdef ARB_STATS_EN
    step(2, 2, 1'b0);
    en_mask = 4'b0100;
    add_beats(2, 8, 32'h0208_0000);
    drain("stats");
    for (int s = 0; s < N; s++) begin
      stats_sel = IW'(s);
      step(2, 0, 1'b1);
      step(2, 0, 1'b1);
      @(negedge clk);
      check("stats_count", stats_count, (s == 2) ? 32'd8 : 32'd0);
    end
`endif

    check("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
